// File: rtl/pc_pkg.sv
// Shared types and constants for the 65c02 program counter (pc_unit).
package pc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FIXUP = 1'b1
  } pc_state_t;

  localparam logic [1:0] VEC_NMI = 2'd0;
  localparam logic [1:0] VEC_RES = 2'd1;
  localparam logic [1:0] VEC_IRQ = 2'd2;

  // The reserved encoding 3 behaves as RES.
  function automatic logic [1:0] vec_norm(input logic [1:0] sel);
    return (sel == 2'd3) ? VEC_RES : sel;
  endfunction

endpackage

// File: rtl/pc_if.sv
// Command/data interface between the instruction sequencer (master) and pc_unit (slave).
interface pc_if #(
  parameter int PC_W = 16
);
  logic            vec_load;
  logic [1:0]      vec_sel;
  logic            adb_load;
  logic [PC_W-1:0] adb_in;
  logic            load_low;
  logic            load_high;
  logic [7:0]      db_in;
  logic            increment;
  logic            branch_take;
  logic [7:0]      branch_off;
  logic            db_sel_high;
  logic [PC_W-1:0] pc_out;
  logic [7:0]      db_out;
  logic            page_cross;
  logic            busy;

  modport master (
    output vec_load, vec_sel, adb_load, adb_in, load_low, load_high, db_in,
           increment, branch_take, branch_off, db_sel_high,
    input  pc_out, db_out, page_cross, busy
  );

  modport slave (
    input  vec_load, vec_sel, adb_load, adb_in, load_low, load_high, db_in,
           increment, branch_take, branch_off, db_sel_high,
    output pc_out, db_out, page_cross, busy
  );
endinterface

// File: rtl/pc_branch_adder.sv
// Low-byte relative branch adder: new low byte plus page-cross detect and high-part direction.
module pc_branch_adder (
  input  logic [7:0] low_i,
  input  logic [7:0] off_i,
  output logic [7:0] low_o,
  output logic       cross_o,
  output logic       dir_up_o
);
  logic [8:0] sum;

  assign sum      = {1'b0, low_i} + {1'b0, off_i};
  assign low_o    = sum[7:0];
  // Forward branches cross on carry out; backward branches cross when no carry occurs.
  assign cross_o  = off_i[7] ? ~sum[8] : sum[8];
  assign dir_up_o = ~off_i[7];
endmodule

// File: rtl/pc_unit.sv
// Parametrised program counter with a one-cycle page-cross fix-up state.
// Optional macro SPLIT_CARRY_EN: increments out of low byte 'hFF take a fix-up cycle.
module pc_unit
  import pc_pkg::*;
#(
  parameter int          PC_W     = 16,
  parameter logic [31:0] VEC_BASE = 32'hFFFA
) (
  input  logic fclk,
  input  logic reset,
  pc_if.slave  bus
);
  localparam int HI_TOP = (PC_W > 16) ? 15 : PC_W - 1;
  localparam logic [PC_W-1:0] VB = PC_W'(VEC_BASE);

  pc_state_t        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             dir_up_q, dir_up_d;
  logic             page_cross_q;

  logic [7:0]       br_low;
  logic             br_cross, br_dir_up;
  logic [PC_W-1:0]  vec_addr;
  logic [PC_W-9:0]  hi_adj;

  pc_branch_adder u_badd (
    .low_i    (pc_q[7:0]),
    .off_i    (bus.branch_off),
    .low_o    (br_low),
    .cross_o  (br_cross),
    .dir_up_o (br_dir_up)
  );

  assign vec_addr = VB + PC_W'({vec_norm(bus.vec_sel), 1'b0});
  assign hi_adj   = dir_up_q ? pc_q[PC_W-1:8] + 1'b1 : pc_q[PC_W-1:8] - 1'b1;

  always_comb begin
    pc_d     = pc_q;
    state_d  = IDLE;
    dir_up_d = dir_up_q;
    if (bus.vec_load) begin
      pc_d = vec_addr;
    end else if (state_q == FIXUP) begin
      pc_d[PC_W-1:8] = hi_adj;
    end else if (bus.adb_load) begin
      pc_d = bus.adb_in;
    end else if (bus.load_low || bus.load_high) begin
      if (bus.load_low)  pc_d[7:0]      = bus.db_in;
      if (bus.load_high) pc_d[HI_TOP:8] = bus.db_in[HI_TOP-8:0];
    end else if (bus.branch_take) begin
      pc_d[7:0] = br_low;
      if (br_cross) begin
        state_d  = FIXUP;
        dir_up_d = br_dir_up;
      end
    end else if (bus.increment) begin
`ifdef SPLIT_CARRY_EN
      // Carry into the high part is deferred to the fix-up cycle.
      if (pc_q[7:0] == 8'hFF) begin
        pc_d[7:0] = 8'h00;
        state_d   = FIXUP;
        dir_up_d  = 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
`else
      pc_d = pc_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge fclk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      dir_up_q     <= 1'b0;
      page_cross_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      dir_up_q     <= dir_up_d;
      page_cross_q <= (state_d == FIXUP);
    end
  end

  assign bus.pc_out     = pc_q;
  assign bus.db_out     = bus.db_sel_high ? 8'(pc_q[HI_TOP:8]) : pc_q[7:0];
  assign bus.page_cross = page_cross_q;
  assign bus.busy       = page_cross_q;
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program counter. It generalises the 8-bit low-byte PC latch into a full-width, synchronously clocked PC register. It supports:
- byte-wise data-bus loads
- full address-bus loads
- interrupt/reset vector loads
- increment
- signed relative branch, with a 6502-style page-crossing fix-up cycle

It sits between the instruction sequencer, the data bus (DB) and the address bus (ADB) in the 65c02 core.

Parameters:
PC_W, 16, PC width in bits; legal range 9..32; the high part is PC_W-8 bits.
VEC_BASE, 'hFFFA, address of the NMI vector; RES = VEC_BASE+2, IRQ = VEC_BASE+4.

Ports:
fclk  in  1  core clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
vec_load  in  1  load the vector address selected by vec_sel.
vec_sel  in  2  0 = NMI, 1 = RES, 2 = IRQ, 3 = reserved (treated as RES).
adb_load  in  1  load pc from adb_in.
adb_in  in  PC_W  address bus value.
load_low  in  1  pc[7:0] <= db_in.
load_high  in  1  pc[15:8] <= db_in (bits above 15 unchanged).
db_in  in  8  data bus byte.
increment  in  1  pc <= pc+1.
branch_take  in  1  pc <= pc + sign-extended branch_off.
branch_off  in  8  two's-complement branch offset.
db_sel_high  in  1  selects pc[15:8] (1) or pc[7:0] (0) onto db_out.
pc_out  out  PC_W  current PC.
db_out  out  8  selected PC byte, combinational from the register.
page_cross  out  1  high while the fix-up cycle is pending.
busy  out  1  same as page_cross; the sequencer stalls on it.

Behaviour:
- Reset (sync, active-high): pc = 0, state = IDLE, page_cross = 0, busy = 0. Reset overrides everything, including a pending FIXUP.
- States:
  - IDLE: accepts commands.
  - FIXUP: one cycle; applies the pending high-part adjustment dir (+1 or -1), then returns to IDLE.
- IDLE priority, one action per cycle: vec_load > adb_load > (load_low | load_high) > branch_take > increment. load_low and load_high may both be set and apply together.
- vec_load: pc = VEC_BASE + 2*sel, zero-extended/truncated to PC_W. It is also honoured in FIXUP, where it cancels the fix-up.
- Branch:
  - Compute low' = pc[7:0] + branch_off as a 9-bit sum.
  - Positive offset with carry: page cross, dir = +1.
  - Negative offset with no carry: page cross, dir = -1.
  - No cross: pc[7:0] = low', done in 1 cycle.
  - Cross: pc[7:0] = low'[7:0], enter FIXUP; the high part changes on the next edge (2 cycles total).
- Increment:
  - Full-width, 1 cycle.
  - At all-ones, pc wraps to 0 with no flag.
- FIXUP:
  - pc[PC_W-1:8] = high ± 1, modulo 2^(PC_W-8).
  - All commands except reset and vec_load are ignored; the sequencer must not issue them while busy.
- page_cross and busy are registered outputs. They are 1 exactly during the FIXUP cycle.

Optional Feature:
SPLIT_CARRY_EN:
- Defined: an increment where pc[7:0] == 'hFF writes low = 'h00 and enters FIXUP with dir = +1. The increment therefore takes 2 cycles, and page_cross/busy are asserted for that cycle, matching the original split PCL/PCH carry behaviour.
- Undefined: increment is a single-cycle full-width add, as described above.

Decomposition:
Shared package pc_pkg holds:
- state enum pc_state_t {IDLE, FIXUP}
- vector select constants VEC_NMI = 0, VEC_RES = 1, VEC_IRQ = 2

One sub-module, pc_branch_adder: combinational 8-bit add producing low', cross and dir.

Test Plan:
1. reset=1 with increment=1 -> pc_out = 0, busy = 0; after reset drops, vec_load with sel = 1 -> pc_out = 'hFFFC next cycle.
2. pc = 'h12F0, branch_take, off = 'h05 -> pc = 'h12F5 in 1 cycle, page_cross stays 0.
3. pc = 'h12F0, off = 'h20 -> cycle 1: pc = 'h1210, page_cross = 1; cycle 2: pc = 'h1310, page_cross = 0.
4. pc = 'h1205, off = 'hF0 (-16) -> 'h12F5 then 'h11F5; increment issued during FIXUP is ignored.
5. load_low = 'h34 and load_high = 'h12 together -> pc = 'h1234; with adb_load = 'hABCD in the same cycle -> pc = 'hABCD.
6. pc = 'h12FF, increment -> without SPLIT_CARRY_EN: 'h1300 in 1 cycle; with it: 'h1200 then 'h1300, busy = 1 for one cycle. pc = 'hFFFF, increment -> 'h0000.
